imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader for the pipelined MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes those words into instruction memory at consecutive addresses from 0, then checks a trailing XOR checksum. It holds the core in reset until a load completes cleanly, and sits directly upstream of the IF stage's instruction memory.

## Interface

Parameters:
- ADDR_WIDTH, 8, instruction-memory address width; capacity 2^ADDR_WIDTH words
- INST_WIDTH, 16, instruction word width; fixed at 16 (two bytes per word)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  one clock; reset is asynchronous and active-low
- byteData  input  8  incoming stream byte
- byteValid  input  1  byteData valid this cycle
- byteReady  output  1  loader can accept a byte this cycle
- reload  input  1  single-cycle request to start a new load; honoured only in DONE
- memWriteEn  output  1  instruction-memory write strobe, one cycle per word
- memWriteAddr  output  ADDR_WIDTH  write address
- memWriteData  output  INST_WIDTH  write data
- coreHold  output  1  high holds the core in reset; drives the core's reset path
- done  output  1  load finished (good or bad)
- error  output  1  checksum mismatch on last load

## Operation

Stream format:
- 1 length byte N: word count, where N=0 means 2^ADDR_WIDTH words.
- 2N data bytes, high byte first per word.
- 1 checksum byte: the XOR of all 2N data bytes. The length byte is excluded.

Acceptance rule:
- A byte is accepted on a rising edge with byteValid && byteReady.
- byteReady is combinational from state: 1 in LEN, HI, LO and CHK; 0 in DONE.

State machine:
- LEN:
  - on accept, load remaining = (N==0 ? 2^ADDR_WIDTH : N); remaining is ADDR_WIDTH+1 bits.
  - clear checksum accumulator; go to HI.
- HI: on accept, latch hiByte and XOR it into the checksum; go to LO.
- LO: on accept:
  - register memWriteData = {hiByte, byteData} and memWriteEn = 1 for the next cycle.
  - XOR the byte into the checksum and decrement remaining.
  - if remaining was 1, go to CHK; else go to HI.
- CHK: on accept:
  - error = (byteData != checksum); done = 1.
  - coreHold = error, so it stays 1 on mismatch and drops to 0 on match.
  - go to DONE.
- DONE:
  - idle; byteReady = 0.
  - on reload: go to LEN, clear done, clear error, set coreHold = 1, reset write pointer to 0.

Address rule:
- memWriteAddr holds the address of the word being written while memWriteEn = 1.
- The write pointer increments by 1 after each write, modulo 2^ADDR_WIDTH.
- A 2^ADDR_WIDTH-word load leaves the pointer wrapped to 0. No overflow flag.

Boundary and priority rules:
- Gaps (byteValid = 0) in any state: no state change, no write.
- reload outside DONE is ignored.
- reload and byteValid together in DONE: reload is taken; the byte is not accepted (byteReady = 0 that cycle).
- Reset asserted mid-load: all state is cleared immediately and asynchronously, and the partial load is abandoned. Memory contents already written are left as is.

## Timing

Reset values:
- State LEN; byteReady 1.
- memWriteEn 0, memWriteAddr 0, memWriteData 0.
- coreHold 1, done 0, error 0.

Latencies:
- Write: memWriteEn pulses the cycle after the LO-byte accept edge, for exactly one cycle. Address and data are stable during that cycle.
- Back-to-back: the maximum rate is one byte per cycle, giving one write every 2 cycles. Writes never overlap.
- Completion: done, error and coreHold update on the same edge that accepts the checksum byte. The last memWriteEn occurred at least 1 cycle earlier.
- Reload: done, error and coreHold update on the edge sampling reload. byteReady rises the next cycle.

## Test plan

- Good load: N=2, data 12 34 AB CD, checksum 40, sent back-to-back.
  - Required: writes (00,1234) then (01,ABCD).
  - done=1, error=0, coreHold falls on the checksum edge.
- Bad checksum: the same stream with checksum 41.
  - Required: both writes occur; done=1, error=1, coreHold stays 1.
- Full capacity: N=00 then 512 bytes, where word k is {k, ~k} and the checksum is correct.
  - Required: 256 writes with the last at addr FF; pointer wraps to 00.
  - done=1, error=0.
- Gaps: good load with byteValid deasserted for 3 cycles between every byte.
  - Required: identical write sequence and result; no spurious memWriteEn.
- Reset mid-load: assert reset after the HI byte of word 1.
  - Required: all outputs return to their reset values asynchronously.
  - A fresh good load afterwards writes starting at addr 00.
- Reload: after a good load, pulse reload together with byteValid=1.
  - Required: the byte is ignored; coreHold=1 and done=0 next cycle.
  - A second load then writes from addr 00.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the boot loader.
// The loader connects through the slave modport; the host and the IF stage connect through master.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 16
);
    logic [7:0]            byteData;
    logic                  byteValid;
    logic                  byteReady;
    logic                  reload;
    logic                  memWriteEn;
    logic [ADDR_WIDTH-1:0] memWriteAddr;
    logic [INST_WIDTH-1:0] memWriteData;
    logic                  coreHold;
    logic                  done;
    logic                  error;

    modport slave (
        input  byteData, byteValid, reload,
        output byteReady, memWriteEn, memWriteAddr, memWriteData, coreHold, done, error
    );

    modport master (
        output byteData, byteValid, reload,
        input  byteReady, memWriteEn, memWriteAddr, memWriteData, coreHold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian 16-bit words from a byte stream, writes them
// from address 0 upward, verifies a trailing XOR checksum and gates the core's reset.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    imem_loader_if.slave   bus
);
    localparam logic [2:0] S_LEN  = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam int         RW     = ADDR_WIDTH + 1;

    logic [2:0]            r_state;
    logic [RW-1:0]         r_remaining;
    logic [7:0]            r_csum;
    logic [7:0]            r_hi;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [INST_WIDTH-1:0] r_wdata;
    logic                  r_wen;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_accept;
    logic [RW-1:0]         w_len;
    logic                  w_bad;

    assign w_ready  = (r_state != S_DONE);
    assign w_accept = bus.byteValid && w_ready;
    // A zero length byte stands for a full-capacity load.
    assign w_len    = (bus.byteData == 8'd0) ? (RW'(1) << ADDR_WIDTH) : RW'(bus.byteData);
    assign w_bad    = (bus.byteData != r_csum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LEN;
            r_remaining <= '0;
            r_csum      <= '0;
            r_hi        <= '0;
            r_ptr       <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_hold      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                S_LEN: if (w_accept) begin
                    r_remaining <= w_len;
                    r_csum      <= '0;
                    r_state     <= S_HI;
                end
                S_HI: if (w_accept) begin
                    r_hi    <= bus.byteData;
                    r_csum  <= r_csum ^ bus.byteData;
                    r_state <= S_LO;
                end
                S_LO: if (w_accept) begin
                    r_wen       <= 1'b1;
                    r_waddr     <= r_ptr;
                    r_wdata     <= INST_WIDTH'({r_hi, bus.byteData});
                    r_ptr       <= r_ptr + 1'b1;
                    r_csum      <= r_csum ^ bus.byteData;
                    r_remaining <= r_remaining - 1'b1;
                    r_state     <= (r_remaining == RW'(1)) ? S_CHK : S_HI;
                end
                S_CHK: if (w_accept) begin
                    r_err   <= w_bad;
                    r_hold  <= w_bad;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: if (bus.reload) begin
                    r_state <= S_LEN;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_hold  <= 1'b1;
                    r_ptr   <= '0;
                end
                default: r_state <= S_LEN;
            endcase
        end
    end

    assign bus.byteReady    = w_ready;
    assign bus.memWriteEn   = r_wen;
    assign bus.memWriteAddr = r_waddr;
    assign bus.memWriteData = r_wdata;
    assign bus.coreHold     = r_hold;
    assign bus.done         = r_done;
    assign bus.error        = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a queue of expected (addr,data) writes and expected
// status flags derived from the stream format, checked every cycle on the falling edge.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    imem_loader_if #(.ADDR_WIDTH(8), .INST_WIDTH(16)) bus ();

    imem_loader #(.ADDR_WIDTH(8), .INST_WIDTH(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [23:0] wq[$];     // expected writes {addr, data}
    logic [23:0] wlog[$];   // observed writes
    logic [7:0]  db[512];
    logic [7:0]  last_cs;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_hold = 1'b1;
    logic        prev_wen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.memWriteEn) begin
            chk("wen_back_to_back", {31'd0, prev_wen}, 32'd0);
            chk("write_was_expected", {31'd0, wq.size() != 0}, 32'd1);
            if (wq.size() != 0)
                chk("write_addr_data", {8'd0, bus.memWriteAddr, bus.memWriteData}, {8'd0, wq.pop_front()});
            wlog.push_back({bus.memWriteAddr, bus.memWriteData});
        end
        prev_wen = bus.memWriteEn;
        chk("done",      {31'd0, bus.done},      {31'd0, exp_done});
        chk("error",     {31'd0, bus.error},     {31'd0, exp_err});
        chk("coreHold",  {31'd0, bus.coreHold},  {31'd0, exp_hold});
        chk("byteReady", {31'd0, bus.byteReady}, {31'd0, !exp_done});
    end

    // Called just after a rising edge; returns just after the edge that ends the gap.
    task automatic send(input logic [7:0] b, input int gap, input bit noise);
        bus.byteData  = b;
        bus.byteValid = 1'b1;
        bus.reload    = noise && ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        bus.byteValid = 1'b0;
        bus.reload    = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic run_load(input int nwords, input logic [7:0] lenb, input logic [7:0] cxor,
                            input int gap, input bit noise);
        logic [7:0] cs;
        cs = 8'd0;
        for (int k = 0; k < nwords; k++) begin
            wq.push_back({8'(k), db[2*k], db[2*k+1]});
            cs = cs ^ db[2*k] ^ db[2*k+1];
        end
        last_cs = cs;
        send(lenb, gap, noise);
        for (int i = 0; i < 2*nwords; i++) send(db[i], gap, noise);
        send(cs ^ cxor, 0, noise);
        exp_done = 1'b1;
        exp_err  = (cxor != 8'd0);
        exp_hold = exp_err;
        chk("load_done",   {31'd0, bus.done},     32'd1);
        chk("load_error",  {31'd0, bus.error},    {31'd0, cxor != 8'd0});
        chk("load_hold",   {31'd0, bus.coreHold}, {31'd0, cxor != 8'd0});
        chk("writes_left", wq.size(),             32'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_reload(input bit with_byte);
        bus.byteData  = 8'h01;
        bus.byteValid = 1'b1;
        @(posedge clk); #1;
        bus.byteValid = with_byte;
        bus.reload    = 1'b1;
        @(posedge clk); #1;
        bus.reload    = 1'b0;
        bus.byteValid = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_hold = 1'b1;
        chk("reload_hold",  {31'd0, bus.coreHold},  32'd1);
        chk("reload_done",  {31'd0, bus.done},      32'd0);
        chk("reload_ready", {31'd0, bus.byteReady}, 32'd1);
    endtask

    task automatic check_reset_vals();
        chk("rst_wen",   {31'd0, bus.memWriteEn}, 32'd0);
        chk("rst_addr",  {24'd0, bus.memWriteAddr}, 32'd0);
        chk("rst_data",  {16'd0, bus.memWriteData}, 32'd0);
        chk("rst_hold",  {31'd0, bus.coreHold}, 32'd1);
        chk("rst_done",  {31'd0, bus.done}, 32'd0);
        chk("rst_error", {31'd0, bus.error}, 32'd0);
        chk("rst_ready", {31'd0, bus.byteReady}, 32'd1);
    endtask

    task automatic load_basic();
        db[0] = 8'h12; db[1] = 8'h34; db[2] = 8'hAB; db[3] = 8'hCD;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byteData = 8'd0; bus.byteValid = 1'b0; bus.reload = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_vals();
        @(posedge clk); #1 reset = 1'b1;

        // good load, back-to-back
        load_basic(); wlog.delete();
        run_load(2, 8'h02, 8'h00, 0, 0);
        chk("model_csum_good", {24'd0, last_cs}, 32'h40);
        chk("good_nwrites", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            chk("good_w0", {8'd0, wlog[0]}, 32'h001234);
            chk("good_w1", {8'd0, wlog[1]}, 32'h01ABCD);
        end
        do_reload(0);

        // bad checksum
        wlog.delete();
        run_load(2, 8'h02, 8'h01, 0, 0);
        chk("bad_nwrites", wlog.size(), 32'd2);
        do_reload(0);

        // full capacity, word k = {k, ~k}
        for (int k = 0; k < 256; k++) begin db[2*k] = 8'(k); db[2*k+1] = ~8'(k); end
        wlog.delete();
        run_load(256, 8'h00, 8'h00, 0, 0);
        chk("model_csum_full", {24'd0, last_cs}, 32'h00);
        chk("full_nwrites", wlog.size(), 32'd256);
        if (wlog.size() == 256) chk("full_last", {8'd0, wlog[255]}, 32'hFFFF00);
        do_reload(0);

        // gaps of 3 idle cycles between bytes
        load_basic(); wlog.delete();
        run_load(2, 8'h02, 8'h00, 3, 0);
        chk("gap_nwrites", wlog.size(), 32'd2);
        if (wlog.size() == 2) chk("gap_w1", {8'd0, wlog[1]}, 32'h01ABCD);
        do_reload(0);

        // reset after the HI byte of word 1
        wq.push_back(24'h001234);
        send(8'h02, 0, 0); send(8'h12, 0, 0); send(8'h34, 0, 0); send(8'hAB, 0, 0);
        #2 reset = 1'b0;
        exp_done = 1'b0; exp_err = 1'b0; exp_hold = 1'b1;
        wq.delete();
        #1 check_reset_vals();
        @(posedge clk); #1 reset = 1'b1;
        wlog.delete();
        run_load(2, 8'h02, 8'h00, 0, 0);
        if (wlog.size() == 2) chk("post_reset_w0", {8'd0, wlog[0]}, 32'h001234);

        // reload coinciding with a valid byte; the byte must be dropped
        do_reload(1);
        wlog.delete();
        run_load(2, 8'h02, 8'h00, 0, 0);
        chk("post_reload_nwrites", wlog.size(), 32'd2);

        // randomized loads with reload noise outside DONE
        for (int t = 0; t < 16; t++) begin
            int n;
            logic [7:0] cx;
            do_reload($urandom_range(0, 1));
            n = $urandom_range(1, 9);
            for (int i = 0; i < 2*n; i++) db[i] = 8'($urandom_range(0, 255));
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_load(n, 8'(n), cx, $urandom_range(0, 2), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
